// File: rtl/onn_relax_ctrl.sv
// Relaxation-loop sequencer for an oscillatory neural network: loads a pattern,
// samples the synapse array after a settle time and detects convergence.
module onn_relax_ctrl #(
   parameter int N             = 15,
   parameter int SETTLE        = 1,
   parameter int STABLE_SWEEPS = 2,
   parameter int MAX_ITER      = 64,
   parameter int ITER_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [N-1:0]      pattern_in,
   input  logic [N-1:0]      nin,
   output logic [N-1:0]      nout,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic [ITER_W-1:0] iter_count,
   output logic [N-1:0]      result
);

   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int STB_W = $clog2(STABLE_SWEEPS + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   state_t             r_state;
   logic               r_mode;
   logic [N-1:0]       r_pattern;
   logic [SET_W-1:0]   r_settle;
   logic [IDX_W-1:0]   r_idx;
   logic [STB_W-1:0]   r_stable;
   logic               r_changed;

   logic               w_update;
   logic [N-1:0]       w_next_nout;
   logic               w_flip;
   logic               w_sweep_end;
   logic               w_changed;
   logic [STB_W-1:0]   w_stable_next;
   logic [ITER_W-1:0]  w_iter_next;
   logic               w_conv;
   logic               w_finish;

   // Post-update state and sweep bookkeeping for the current RUN cycle.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_next_nout = nout;
      w_flip      = 1'b0;
      w_update    = (r_state == S_RUN) && (r_settle == SET_W'(SETTLE - 1));
      if (r_mode) begin
         w_next_nout[r_idx] = nin[r_idx];
         w_flip             = nin[r_idx] ^ nout[r_idx];
      end else begin
         w_next_nout = nin;
         w_flip      = (nin != nout);
      end
      w_sweep_end   = w_update && (!r_mode || (r_idx == IDX_W'(N - 1)));
      w_changed     = r_changed | w_flip;
      w_stable_next = w_changed ? '0 : r_stable + 1'b1;
      w_iter_next   = iter_count + 1'b1;
      w_conv        = (w_stable_next == STB_W'(STABLE_SWEEPS));
      w_finish      = w_sweep_end && (w_conv || (w_iter_next == ITER_W'(MAX_ITER)));
   end

   // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_mode     <= 1'b0;
         r_pattern  <= '0;
         r_settle   <= '0;
         r_idx      <= '0;
         r_stable   <= '0;
         r_changed  <= 1'b0;
         nout       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         converged  <= 1'b0;
         iter_count <= '0;
         result     <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_LOAD;
                  r_mode     <= mode;
                  r_pattern  <= pattern_in;
                  busy       <= 1'b1;
                  converged  <= 1'b0;
                  iter_count <= '0;
                  r_stable   <= '0;
                  r_idx      <= '0;
                  r_changed  <= 1'b0;
               end
            end
            S_LOAD: begin
               nout     <= r_pattern;
               r_settle <= '0;
               r_state  <= S_RUN;
            end
            S_RUN: begin
               if (w_update) begin
                  r_settle <= '0;
                  nout     <= w_next_nout;
                  if (r_mode) r_idx <= w_sweep_end ? '0 : r_idx + 1'b1;
                  if (w_sweep_end) begin
                     iter_count <= w_iter_next;
                     r_stable   <= w_stable_next;
                     r_changed  <= 1'b0;
                     if (w_finish) begin
                        r_state   <= S_IDLE;
                        result    <= w_next_nout;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        converged <= w_conv;
                     end
                  end else begin
                     r_changed <= w_changed;
                  end
               end else begin
                  r_settle <= r_settle + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_onn_relax_ctrl.sv
// Directed bench for onn_relax_ctrl: four parameterisations, a behavioural synapse
// model, and a scoreboard of expected run outcomes compared on each done pulse.
module tb_onn_relax_ctrl;

   localparam int N = 15;

   typedef struct {
      int           id;
      logic         conv;
      int           iter;
      logic [N-1:0] res;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start [4];
   logic         mode;
   logic [N-1:0] pattern;
   logic [N-1:0] nin    [4];
   logic [N-1:0] nout   [4];
   logic [N-1:0] result [4];
   logic         busy   [4];
   logic         done   [4];
   logic         conv   [4];
   logic [7:0]   iter   [4];

   int   model_sel = 0;
   int   cyc       = 0;
   int   n_checks  = 0;
   int   n_errors  = 0;
   exp_t sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synapse model: 0 identity, 1 invert, 2 shift a one in from the bottom.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         nin[i] = nout[i];
         case (model_sel)
            1:       nin[i] = ~nout[i];
            2:       nin[i] = {nout[i][N-2:0], 1'b1};
            default: nin[i] = nout[i];
         endcase
      end
   end

   // Instances: 0 default, 1 MAX_ITER=8, 2 MAX_ITER=4, 3 SETTLE=3.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int ST = (g == 3) ? 3 : 1;
      localparam int MI = (g == 1) ? 8 : ((g == 2) ? 4 : 64);
      onn_relax_ctrl #(
         .N(N), .SETTLE(ST), .STABLE_SWEEPS(2), .MAX_ITER(MI), .ITER_W(8)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .start      (start[g]),
         .mode       (mode),
         .pattern_in (pattern),
         .nin        (nin[g]),
         .nout       (nout[g]),
         .busy       (busy[g]),
         .done       (done[g]),
         .converged  (conv[g]),
         .iter_count (iter[g]),
         .result     (result[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one start pulse; E0 is the next rising edge. Returns #1 after E0.
   task automatic launch(input int id, input logic md, input logic [N-1:0] pat, input logic push,
                         input logic ec, input int ei, input logic [N-1:0] er, input int fin);
      @(negedge clk);
      start[id] = 1'b1;
      mode      = md;
      pattern   = pat;
      if (push) sb.push_back('{id, ec, ei, er, cyc + 1 + fin});
      @(posedge clk);
      #1;
      start[id] = 1'b0;
      pattern   = ~pat;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic check_reset_outputs(input int id);
      check("rst_nout",   32'(nout[id]),   32'd0);
      check("rst_result", 32'(result[id]), 32'd0);
      check("rst_busy",   32'(busy[id]),   32'd0);
      check("rst_done",   32'(done[id]),   32'd0);
      check("rst_conv",   32'(conv[id]),   32'd0);
      check("rst_iter",   32'(iter[id]),   32'd0);
   endtask

   // Scoreboard: every done pulse must match the oldest expected outcome.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         if (rst_n === 1'b1 && done[i] === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(done[i]), 32'd0);
            end else begin
               e = sb.pop_front();
               check("done_id",      32'(i),         32'(e.id));
               check("converged",    32'(conv[i]),   32'(e.conv));
               check("iter_count",   32'(iter[i]),   32'(e.iter));
               check("result",       32'(result[i]), 32'(e.res));
               check("done_cycle",   32'(cyc),       32'(e.cyc));
               check("busy_in_done", 32'(busy[i]),   32'd0);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] prev;
      rst_n   = 1'b0;
      mode    = 1'b0;
      pattern = '0;
      for (int i = 0; i < 4; i++) start[i] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs(0);
      check_reset_outputs(3);
      rst_n = 1'b1;

      // Synchronous fixed point: minimum run, busy E0..E3.
      model_sel = 0;
      launch(0, 1'b0, 15'h1234, 1'b1, 1'b1, 2, 15'h1234, 3);
      check("t1_busy_e0", 32'(busy[0]), 32'd1);
      @(posedge clk); #1;
      check("t1_nout_e1", 32'(nout[0]), 32'h1234);
      check("t1_busy_e1", 32'(busy[0]), 32'd1);
      @(posedge clk); #1;
      check("t1_busy_e2", 32'(busy[0]), 32'd1);
      @(posedge clk); #1;
      check("t1_busy_e3", 32'(busy[0]), 32'd0);
      check("t1_done_e3", 32'(done[0]), 32'd1);
      wait_done(5);

      // Synchronous oscillation hits MAX_ITER=8.
      model_sel = 1;
      launch(1, 1'b0, 15'h00FF, 1'b1, 1'b0, 8, 15'h00FF, 9);
      wait_done(20);

      // Shift-in ones, with a start pulse and mode/pattern change mid-run.
      model_sel = 2;
      launch(0, 1'b0, 15'h0000, 1'b1, 1'b1, 17, 15'h7FFF, 18);
      repeat (4) @(posedge clk);
      #1;
      start[0] = 1'b1;
      mode     = 1'b1;
      pattern  = 15'h1111;
      @(posedge clk); #1;
      start[0] = 1'b0;
      mode     = 1'b0;
      wait_done(40);

      // Sequential fixed point.
      model_sel = 0;
      launch(0, 1'b1, 15'h2A5A, 1'b1, 1'b1, 2, 15'h2A5A, 31);
      wait_done(40);

      // Sequential oscillation, MAX_ITER=4: one bit per update in index order.
      model_sel = 1;
      launch(2, 1'b1, 15'h5A5A, 1'b1, 1'b0, 4, 15'h5A5A, 61);
      @(posedge clk); #1;
      check("t5_load", 32'(nout[2]), 32'h5A5A);
      prev = nout[2];
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         check("t5_flip", 32'(nout[2] ^ prev), 32'd1 << ((k - 1) % 15));
         prev = nout[2];
      end
      wait_done(5);

      // SETTLE=3 fixed point: done only after E7.
      model_sel = 0;
      launch(3, 1'b0, 15'h0ACE, 1'b1, 1'b1, 2, 15'h0ACE, 7);
      for (int e = 1; e <= 7; e++) begin
         @(posedge clk); #1;
         check("t6_nout", 32'(nout[3]), 32'h0ACE);
         check("t6_done", 32'(done[3]), (e == 7) ? 32'd1 : 32'd0);
      end
      wait_done(5);

      // SETTLE=3 shift-in: nout moves only at E4, E7, E10.
      model_sel = 2;
      launch(3, 1'b0, 15'h0000, 1'b1, 1'b1, 17, 15'h7FFF, 52);
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); #1;
         check("t6_hold", 32'(nout[3]), (32'd1 << ((e - 1) / 3)) - 32'd1);
      end
      wait_done(60);

      // start held through done: second run begins at E4.
      model_sel = 0;
      @(negedge clk);
      start[0] = 1'b1;
      mode     = 1'b0;
      pattern  = 15'h3C3C;
      sb.push_back('{0, 1'b1, 2, 15'h3C3C, cyc + 1 + 3});
      sb.push_back('{0, 1'b1, 2, 15'h3C3C, cyc + 1 + 7});
      repeat (4) @(posedge clk);
      #1;
      check("b2b_conv_e3", 32'(conv[0]), 32'd1);
      check("b2b_done_e3", 32'(done[0]), 32'd1);
      @(posedge clk); #1;
      check("b2b_conv_e4", 32'(conv[0]), 32'd0);
      check("b2b_busy_e4", 32'(busy[0]), 32'd1);
      check("b2b_iter_e4", 32'(iter[0]), 32'd0);
      start[0] = 1'b0;
      wait_done(20);

      // Reset for one edge mid-run: run abandoned, no done afterwards.
      model_sel = 1;
      launch(0, 1'b0, 15'h0F0F, 1'b0, 1'b0, 0, 15'h0000, 0);
      repeat (9) @(posedge clk);
      #1;
      check("rst_run_busy", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_reset_outputs(0);
      repeat (80) @(posedge clk);
      #1;
      check("rst_after_busy", 32'(busy[0]), 32'd0);
      check("rst_after_iter", 32'(iter[0]), 32'd0);
      check("rst_after_nout", 32'(nout[0]), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
